// File: rtl/rsa_modexp_pipe_if.sv
// Request/result handshake bundle for rsa_modexp_pipe: operands in, result out.
// master drives requests and consumes results; slave is the exponentiator.
interface rsa_modexp_pipe_if #(
   parameter int WIDTH     = 256,
   parameter int EXP_WIDTH = WIDTH
);
   logic                 i_start;
   logic                 o_ready;
   logic [WIDTH-1:0]     i_a;
   logic [EXP_WIDTH-1:0] i_d;
   logic [WIDTH-1:0]     i_n;
   logic                 i_abort;
   logic [WIDTH-1:0]     o_result;
   logic                 o_valid;
   logic                 i_result_ready;
   logic                 o_error;
   logic                 o_busy;

   modport master (
      output i_start, i_a, i_d, i_n, i_abort, i_result_ready,
      input  o_ready, o_result, o_valid, o_error, o_busy
   );

   modport slave (
      input  i_start, i_a, i_d, i_n, i_abort, i_result_ready,
      output o_ready, o_result, o_valid, o_error, o_busy
   );
endinterface

// File: rtl/rsa_modexp_pipe.sv
// Modular exponentiator a^d mod n: right-to-left square-and-multiply built on two
// concurrent bit-serial Montgomery multipliers (A: m*t, B: t*t).
module rsa_modexp_pipe #(
   parameter int WIDTH     = 256,
   parameter int EXP_WIDTH = WIDTH
) (
   input logic                i_clk,
   input logic                i_rst,
   rsa_modexp_pipe_if.slave   bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_PREP  = 3'd2;
   localparam logic [2:0] S_EXP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]           state;
   logic [WIDTH-1:0]     n_r, t, m, x_a, x_b, result_r;
   logic [EXP_WIDTH-1:0] d_sh;
   logic [CNT_W-1:0]     cnt;
   logic [WIDTH+1:0]     s_a, s_b;
   logic                 valid_r, error_r;

   // One Montgomery iteration; s stays below 2n so WIDTH+2 bits never overflow.
   function automatic logic [WIDTH+1:0] mm_step(input logic [WIDTH+1:0] s,
                                                input logic xj,
                                                input logic [WIDTH-1:0] y,
                                                input logic [WIDTH-1:0] n);
      logic [WIDTH+1:0] acc;
      acc = s + (xj ? {2'b00, y} : '0);
      acc = acc + (acc[0] ? {2'b00, n} : '0);
      return acc >> 1;
   endfunction

   function automatic logic [WIDTH-1:0] mm_final(input logic [WIDTH+1:0] s,
                                                 input logic [WIDTH-1:0] n);
      return WIDTH'((s >= {2'b00, n}) ? s - {2'b00, n} : s);
   endfunction

   logic [WIDTH:0]       t_dbl;
   logic [WIDTH-1:0]     t_prep, m_fin, t_fin;
   logic [WIDTH+1:0]     s_a_nxt, s_b_nxt;
   logic [EXP_WIDTH-1:0] d_nxt;
   logic                 bad_req;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      t_dbl   = {t, 1'b0};
      t_prep  = WIDTH'((t_dbl >= {1'b0, n_r}) ? t_dbl - {1'b0, n_r} : t_dbl);
      s_a_nxt = mm_step(s_a, x_a[0], t, n_r);
      s_b_nxt = mm_step(s_b, x_b[0], t, n_r);
      m_fin   = d_sh[0] ? mm_final(s_a, n_r) : m;
      t_fin   = mm_final(s_b, n_r);
      d_nxt   = d_sh >> 1;
      bad_req = !bus.i_n[0] || (bus.i_n < WIDTH'(3)) || (bus.i_a >= bus.i_n);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state    <= S_IDLE;
         n_r      <= '0;
         t        <= '0;
         m        <= '0;
         x_a      <= '0;
         x_b      <= '0;
         d_sh     <= '0;
         cnt      <= '0;
         s_a      <= '0;
         s_b      <= '0;
         result_r <= '0;
         valid_r  <= 1'b0;
         error_r  <= 1'b0;
      end else if (bus.i_abort && (state == S_CHECK || state == S_PREP || state == S_EXP)) begin
         state    <= S_IDLE;
         n_r      <= '0;
         t        <= '0;
         m        <= '0;
         x_a      <= '0;
         x_b      <= '0;
         d_sh     <= '0;
         cnt      <= '0;
         s_a      <= '0;
         s_b      <= '0;
         result_r <= '0;
         valid_r  <= 1'b0;
         error_r  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (bus.i_start) begin
               n_r      <= bus.i_n;
               t        <= bus.i_a;
               d_sh     <= bus.i_d;
               m        <= WIDTH'(1);
               cnt      <= '0;
               result_r <= '0;
               error_r  <= 1'b0;
               state    <= bad_req ? S_CHECK : S_PREP;
            end
            S_CHECK: begin
               result_r <= '0;
               error_r  <= 1'b1;
               valid_r  <= 1'b1;
               state    <= S_DONE;
            end
            // Bring a into the Montgomery domain: t = a * 2^WIDTH mod n by repeated doubling.
            S_PREP: begin
               t <= t_prep;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  cnt <= '0;
                  if (d_sh == '0) begin
                     result_r <= WIDTH'(1);
                     valid_r  <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     s_a   <= '0;
                     s_b   <= '0;
                     x_a   <= m;
                     x_b   <= t_prep;
                     state <= S_EXP;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_EXP: begin
               if (cnt != CNT_W'(WIDTH)) begin
                  if (d_sh[0]) s_a <= s_a_nxt;
                  s_b <= s_b_nxt;
                  x_a <= x_a >> 1;
                  x_b <= x_b >> 1;
                  cnt <= cnt + CNT_W'(1);
               end else begin
                  // m stays in the plain domain: MM(m, a^(2^i) * R) = m * a^(2^i) mod n.
                  m    <= m_fin;
                  t    <= t_fin;
                  d_sh <= d_nxt;
                  cnt  <= '0;
                  s_a  <= '0;
                  s_b  <= '0;
                  x_a  <= m_fin;
                  x_b  <= t_fin;
                  if (d_nxt == '0) begin
                     result_r <= m_fin;
                     valid_r  <= 1'b1;
                     state    <= S_DONE;
                  end
               end
            end
            S_DONE: if (bus.i_result_ready) begin
               valid_r <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_ready  = (state == S_IDLE);
   assign bus.o_busy   = (state == S_PREP) || (state == S_EXP);
   assign bus.o_valid  = valid_r;
   assign bus.o_error  = error_r;
   assign bus.o_result = result_r;
endmodule

// File: tb/tb_rsa_modexp_pipe.sv
// Bench for rsa_modexp_pipe: directed 8-bit jobs plus a 256-bit random sweep,
// checked against a plain square-and-multiply model with wide arithmetic.
module tb_rsa_modexp_pipe;
   logic clk;
   logic rst;
   int   checks_total;
   int   checks_passed;
   int   checks_failed;

   rsa_modexp_pipe_if #(.WIDTH(8),   .EXP_WIDTH(8))   bus8 ();
   rsa_modexp_pipe_if #(.WIDTH(256), .EXP_WIDTH(256)) bus256 ();

   rsa_modexp_pipe #(.WIDTH(8), .EXP_WIDTH(8)) dut8 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus8)
   );

   rsa_modexp_pipe #(.WIDTH(256), .EXP_WIDTH(256)) dut256 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus256)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else begin
         checks_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] ref_modexp(input logic [255:0] a, input logic [255:0] d,
                                               input logic [255:0] n);
      logic [511:0] r, b, nn;
      nn = {256'b0, n};
      r  = 512'd1;
      b  = {256'b0, a} % nn;
      for (int i = 0; i < 256; i++) begin
         if (d[i]) r = (r * b) % nn;
         b = (b * b) % nn;
      end
      return r[255:0];
   endfunction

   function automatic int ref_latency(input int w, input logic [255:0] d);
      int k;
      k = 0;
      for (int i = 0; i < 256; i++) if (d[i]) k = i + 1;
      return w + k * (w + 1);
   endfunction

   task automatic drive(input bit big, input logic start, input logic [255:0] a,
                        input logic [255:0] d, input logic [255:0] n);
      if (big) begin
         bus256.i_start = start; bus256.i_a = a; bus256.i_d = d; bus256.i_n = n;
      end else begin
         bus8.i_start = start; bus8.i_a = a[7:0]; bus8.i_d = d[7:0]; bus8.i_n = n[7:0];
      end
   endtask

   task automatic set_ctl(input bit big, input logic abort, input logic rr);
      if (big) begin bus256.i_abort = abort; bus256.i_result_ready = rr; end
      else     begin bus8.i_abort   = abort; bus8.i_result_ready   = rr; end
   endtask

   task automatic sample(input bit big, output logic v, output logic rdy, output logic bsy,
                         output logic err, output logic [255:0] res);
      if (big) begin
         v = bus256.o_valid; rdy = bus256.o_ready; bsy = bus256.o_busy;
         err = bus256.o_error; res = bus256.o_result;
      end else begin
         v = bus8.o_valid; rdy = bus8.o_ready; bsy = bus8.o_busy;
         err = bus8.o_error; res = {248'b0, bus8.o_result};
      end
   endtask

   // Issue one job, count edges to o_valid, optionally stall the result for `hold`
   // cycles while poking abort/start, then consume it and check the return to IDLE.
   task automatic run_job(input bit big, input string tag, input logic [255:0] a,
                          input logic [255:0] d, input logic [255:0] n, input int hold,
                          output logic [255:0] res, output logic err, output int lat,
                          output bit busy_ok, output bit hold_ok);
      logic v, rdy, bsy, e;
      logic [255:0] r;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      lat     = 0;
      @(negedge clk);
      sample(big, v, rdy, bsy, e, r);
      if (!rdy) busy_ok = 1'b0;
      drive(big, 1'b1, a, d, n);
      @(posedge clk);
      #1;
      drive(big, 1'b0, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            {8{$urandom}}, {8{$urandom}});
      v = 1'b0;
      while (!v && lat < 70000) begin
         @(posedge clk);
         lat++;
         #1;
         sample(big, v, rdy, bsy, e, r);
         if (!v && (!bsy || rdy)) busy_ok = 1'b0;
      end
      if (!v) check({tag, "_timeout"}, {255'b0, v}, 256'd1);
      res = r;
      err = e;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         set_ctl(big, 1'b1, 1'b0);
         drive(big, 1'b1, 256'd3, 256'd1, 256'd5);
         @(posedge clk);
         #1;
         sample(big, v, rdy, bsy, e, r);
         if (!v || rdy || r !== res || e !== err) hold_ok = 1'b0;
      end
      @(negedge clk);
      drive(big, 1'b0, '0, '0, '0);
      set_ctl(big, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      sample(big, v, rdy, bsy, e, r);
      check({tag, "_consumed_valid"}, {255'b0, v}, 256'd0);
      check({tag, "_consumed_ready"}, {255'b0, rdy}, 256'd1);
      @(negedge clk);
      set_ctl(big, 1'b0, 1'b0);
   endtask

   initial begin
      logic [255:0] res, a, d, n;
      logic         err;
      int           lat;
      bit           busy_ok, hold_ok, saw_valid;

      checks_total  = 0;
      checks_passed = 0;
      checks_failed = 0;
      rst = 1'b0;
      drive(1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, '0, '0, '0);
      set_ctl(1'b0, 1'b0, 1'b0);
      set_ctl(1'b1, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",  {255'b0, bus8.o_ready}, 256'd1);
      check("rst_valid",  {255'b0, bus8.o_valid}, 256'd0);
      check("rst_error",  {255'b0, bus8.o_error}, 256'd0);
      check("rst_busy",   {255'b0, bus8.o_busy},  256'd0);
      check("rst_result", {248'b0, bus8.o_result}, 256'd0);
      @(negedge clk);
      rst = 1'b1;

      run_job(1'b0, "a88_d7", 256'd88, 256'd7, 256'd187, 0, res, err, lat, busy_ok, hold_ok);
      check("a88_d7_result", res, 256'd11);
      check("a88_d7_error",  {255'b0, err}, 256'd0);
      check("a88_d7_latency", 256'(lat), 256'd35);
      check("a88_d7_busy", {255'b0, busy_ok}, 256'd1);

      run_job(1'b0, "a11_d23", 256'd11, 256'd23, 256'd187, 10, res, err, lat, busy_ok, hold_ok);
      check("a11_d23_result", res, 256'd88);
      check("a11_d23_latency", 256'(lat), 256'd53);
      check("a11_d23_hold_stable", {255'b0, hold_ok}, 256'd1);

      run_job(1'b0, "d0", 256'd42, 256'd0, 256'd187, 0, res, err, lat, busy_ok, hold_ok);
      check("d0_result", res, 256'd1);
      check("d0_latency", 256'(lat), 256'd8);

      run_job(1'b0, "d1", 256'd5, 256'd1, 256'd187, 0, res, err, lat, busy_ok, hold_ok);
      check("d1_result", res, 256'd5);
      check("d1_latency", 256'(lat), 256'd17);

      run_job(1'b0, "n_even", 256'd5, 256'd3, 256'd186, 0, res, err, lat, busy_ok, hold_ok);
      check("n_even_error", {255'b0, err}, 256'd1);
      check("n_even_result", res, 256'd0);
      check("n_even_latency", 256'(lat), 256'd1);

      run_job(1'b0, "a_ge_n", 256'd200, 256'd3, 256'd187, 0, res, err, lat, busy_ok, hold_ok);
      check("a_ge_n_error", {255'b0, err}, 256'd1);
      check("a_ge_n_result", res, 256'd0);
      check("a_ge_n_latency", 256'(lat), 256'd1);

      // Abort 20 cycles into a job: back to IDLE next edge, no result ever shown.
      saw_valid = 1'b0;
      @(negedge clk);
      drive(1'b0, 1'b1, 256'd88, 256'd7, 256'd187);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, '0, '0, '0);
      repeat (20) begin
         @(posedge clk);
         #1;
         if (bus8.o_valid) saw_valid = 1'b1;
      end
      @(negedge clk);
      set_ctl(1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("abort_ready", {255'b0, bus8.o_ready}, 256'd1);
      check("abort_busy",  {255'b0, bus8.o_busy},  256'd0);
      @(negedge clk);
      set_ctl(1'b0, 1'b0, 1'b0);
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus8.o_valid) saw_valid = 1'b1;
      end
      check("abort_no_valid", {255'b0, saw_valid}, 256'd0);

      run_job(1'b0, "post_abort", 256'd11, 256'd23, 256'd187, 0, res, err, lat, busy_ok, hold_ok);
      check("post_abort_result", res, 256'd88);
      check("post_abort_error", {255'b0, err}, 256'd0);

      // 256-bit sweep: random odd moduli, random bases below n, short and full-length exponents.
      for (int j = 0; j < 3; j++) begin
         n = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         n[255] = 1'b1;
         n[0]   = 1'b1;
         a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} % n;
         d = (j == 2) ? (256'd1 << 255) : 256'($urandom_range(4095, 1));
         run_job(1'b1, "w256", a, d, n, 0, res, err, lat, busy_ok, hold_ok);
         check("w256_result", res, ref_modexp(a, d, n));
         check("w256_error", {255'b0, err}, 256'd0);
         check("w256_latency", 256'(lat), 256'(ref_latency(256, d)));
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
